// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
// Fetch FSM states, PCSrcE encodings, the bubble instruction and a JALR target helper.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    function automatic logic [XLEN-1:0] jalr_align(input logic [XLEN-1:0] target);
        return {target[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: reset > flush > stall > load/bubble.
// A bubble keeps PCD/PCPlus4D so decode still sees the last real PC.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr    <= i_instr;
                r_pc       <= i_pc;
                r_pc_plus4 <= i_pc_plus4;
                r_valid    <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, single-outstanding imem handshake
// with a one-entry hold buffer, feeding the IF/ID register.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic            ImemReqValidF,
    output logic [XLEN-1:0] ImemAddrF,
    input  logic            ImemReqReady,
    input  logic            ImemRspValid,
    input  logic [XLEN-1:0] ImemRspData,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [1:0]      DbgStateF
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic            r_hold_valid;
    logic [XLEN-1:0] r_hold_data;
    logic [XLEN-1:0] w_avail_data;
    logic            w_redirect;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_avail;
    logic            w_consume;

    // Handshake: a request transfers on a cycle with ImemReqValidF && ImemReqReady;
    // its response is a single ImemRspValid pulse some cycles later, never backpressured.
    assign ImemReqValidF = !reset && (r_state == REQ) && !r_hold_valid;
    assign ImemAddrF     = {r_pc[XLEN-1:2], 2'b00};
    assign w_req_fire    = ImemReqValidF && ImemReqReady;
    assign w_rsp_take    = (r_state == WAIT) && ImemRspValid;
    assign w_redirect    = (PCSrcE != PCSRC_PLUS4);
    assign w_avail       = w_rsp_take || r_hold_valid;
    assign w_avail_data  = r_hold_valid ? r_hold_data : ImemRspData;
    assign w_consume     = w_avail && !StallF && !StallD && !FlushD && !w_redirect;
    assign w_pc_plus4    = r_pc + 32'd4;
    assign DbgStateF     = r_state;

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redirect) begin
            w_pc_nxt = (PCSrcE == PCSRC_JALR) ? jalr_align(ALUResultE) : PCTargetE;
        end else if (w_consume) begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    // A response landing in the redirect cycle closes the outstanding request,
    // so there is nothing left to drop and the FSM returns straight to REQ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REQ:     if (w_req_fire) w_state_nxt = w_redirect ? DROP : WAIT;
            WAIT:    if (ImemRspValid) w_state_nxt = REQ;
                     else if (w_redirect) w_state_nxt = DROP;
            DROP:    if (ImemRspValid) w_state_nxt = REQ;
            default: w_state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_hold_valid <= 1'b0;
            r_hold_data  <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_redirect || w_consume) begin
                r_hold_valid <= 1'b0;
            end else if (w_rsp_take) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= ImemRspData;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (FlushD),
        .i_stall    (StallD),
        .i_load     (w_consume),
        .i_instr    (w_avail_data),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (InstrD),
        .o_pc       (PCD),
        .o_pc_plus4 (PCPlus4D),
        .o_valid    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stalls, flushes,
// redirects and memory latency, checked every cycle against a transaction-level model.
module tb_fetch_stage;
    import pipeline_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        ImemReqValidF;
    logic [31:0] ImemAddrF;
    logic        ImemReqReady, ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [1:0]  DbgStateF;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .PCSrcE        (PCSrcE),
        .PCTargetE     (PCTargetE),
        .ALUResultE    (ALUResultE),
        .ImemReqValidF (ImemReqValidF),
        .ImemAddrF     (ImemAddrF),
        .ImemReqReady  (ImemReqReady),
        .ImemRspValid  (ImemRspValid),
        .ImemRspData   (ImemRspData),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .PCPlus4D      (PCPlus4D),
        .ValidD        (ValidD),
        .DbgStateF     (DbgStateF)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC, one outstanding request (possibly stale), held instructions, decode regs.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid, m_busy, m_stale;
    logic [31:0] m_held_q[$];

    // Memory responder: one pending response, delivered when mem_cnt reaches 1.
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] seen_pcs[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic exp_req();
        return !reset && !m_busy && (m_held_q.size() == 0);
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_busy) return REQ;
        return m_stale ? DROP : WAIT;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_held_q.delete();
        m_instr = NOP_INSTR;
        m_pcd   = '0;
        m_pc4   = '0;
        m_valid = 1'b0;
    endtask

    task automatic quiet();
        StallF       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        PCSrcE       = 2'b00;
        PCTargetE    = '0;
        ALUResultE   = '0;
        ImemReqReady = (mem_cnt == 0);
    endtask

    task automatic rand_inputs();
        StallF       = ($urandom_range(0, 4) == 0);
        StallD       = ($urandom_range(0, 4) == 0);
        FlushD       = ($urandom_range(0, 9) == 0);
        PCSrcE       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        PCTargetE    = $urandom;
        ALUResultE   = $urandom;
        ImemReqReady = (mem_cnt == 0) && ($urandom_range(0, 3) != 0);
    endtask

    // One clock: check request side mid-cycle, advance model and memory, check IF/ID after the edge.
    task automatic step();
        logic        acc, redirect, arrive, fresh, have, consume;
        logic [31:0] data, acc_addr;
        ImemRspValid = (mem_cnt == 1);
        ImemRspData  = (mem_cnt == 1) ? mem_data(mem_addr) : $urandom;
        #2;
        check_eq("req_valid", 32'(ImemReqValidF), 32'(exp_req()));
        check_eq("imem_addr", ImemAddrF, {m_pc[31:2], 2'b00});
        check_eq("state", 32'(DbgStateF), 32'(exp_state()));
        acc      = exp_req() && ImemReqReady;
        acc_addr = {m_pc[31:2], 2'b00};
        if (!reset) begin
            redirect = (PCSrcE != 2'b00);
            arrive   = ImemRspValid && m_busy;
            fresh    = arrive && !m_stale;
            have     = (m_held_q.size() > 0) || fresh;
            data     = (m_held_q.size() > 0) ? m_held_q[0] : ImemRspData;
            consume  = have && !StallF && !StallD && !FlushD && !redirect;
            if (FlushD) begin
                m_instr = NOP_INSTR; m_pcd = '0; m_pc4 = '0; m_valid = 1'b0;
            end else if (!StallD) begin
                if (consume) begin
                    m_instr = data; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_instr = NOP_INSTR; m_valid = 1'b0;
                end
            end
            if (redirect || consume) m_held_q.delete();
            else if (fresh) m_held_q.push_back(data);
            if (arrive) begin
                m_busy = 1'b0; m_stale = 1'b0;
            end else if (acc) begin
                m_busy = 1'b1; m_stale = redirect;
            end else if (redirect && m_busy) begin
                m_stale = 1'b1;
            end
            if (redirect) m_pc = (PCSrcE == 2'b10) ? (ALUResultE & ~32'h1) : PCTargetE;
            else if (consume) m_pc = m_pc + 32'd4;
        end
        if (mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_cnt  = $urandom_range(lat_min, lat_max);
            mem_addr = acc_addr;
        end
        @(posedge clk);
        #1;
        check_eq("instr_d", InstrD, m_instr);
        check_eq("pc_d", PCD, m_pcd);
        check_eq("pc_plus4_d", PCPlus4D, m_pc4);
        check_eq("valid_d", 32'(ValidD), 32'(m_valid));
    endtask

    task automatic redirect_step(input logic [1:0] src, input logic [31:0] val, input logic fl);
        quiet();
        PCSrcE     = src;
        PCTargetE  = val;
        ALUResultE = val;
        FlushD     = fl;
        step();
    endtask

    // Reset asserted between edges; outputs must fall to reset values immediately.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        quiet();
        #1;
        check_eq("rst_req_valid", 32'(ImemReqValidF), 32'd0);
        check_eq("rst_instr_d", InstrD, NOP_INSTR);
        check_eq("rst_valid_d", 32'(ValidD), 32'd0);
        check_eq("rst_pc_d", PCD, 32'd0);
        check_eq("rst_pc_plus4_d", PCPlus4D, 32'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        model_reset();
        step();
        reset = 1'b0;

        // Zero-wait memory: a valid instruction every second cycle.
        repeat (6) begin
            quiet();
            step();
            if (ValidD) seen_pcs.push_back(PCD);
        end
        check_eq("zw_count", 32'(seen_pcs.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check_eq("zw_pcd", (i < seen_pcs.size()) ? seen_pcs[i] : 32'hDEAD_BEEF, 32'(4 * i));

        // Stall while the response for 0x4 arrives: held, no new request, then consumed.
        do_reset();
        repeat (3) begin quiet(); step(); end
        repeat (3) begin quiet(); StallF = 1'b1; StallD = 1'b1; step(); end
        check_eq("hold_no_req", 32'(ImemReqValidF), 32'd0);
        quiet();
        step();
        check_eq("hold_pcd", PCD, 32'h4);
        check_eq("hold_valid_d", 32'(ValidD), 32'd1);
        check_eq("hold_next_req", 32'(ImemReqValidF), 32'd1);
        check_eq("hold_next_addr", ImemAddrF, 32'h8);

        // Branch redirect while waiting on 0x8.
        lat_min = 2; lat_max = 2;
        quiet();
        step();
        redirect_step(2'b01, 32'h100, 1'b1);
        check_eq("br_state_drop", 32'(DbgStateF), 32'(DROP));
        check_eq("br_flush_valid", 32'(ValidD), 32'd0);
        quiet();
        step();
        check_eq("br_next_addr", ImemAddrF, 32'h100);
        check_eq("br_next_req", 32'(ImemReqValidF), 32'd1);

        // JALR with odd target.
        lat_min = 1; lat_max = 1;
        quiet();
        step();
        redirect_step(2'b10, 32'h203, 1'b0);
        check_eq("jalr_addr", ImemAddrF, 32'h200);
        check_eq("jalr_state", 32'(DbgStateF), 32'(REQ));
        repeat (2) begin quiet(); step(); end
        check_eq("jalr_pcd", PCD, 32'h202);
        check_eq("jalr_pc4", PCPlus4D, 32'h206);
        check_eq("jalr_instr", InstrD, mem_data(32'h200));

        // PC wrap at the top of the address space.
        redirect_step(2'b01, 32'hFFFF_FFFC, 1'b0);
        repeat (3) begin quiet(); step(); end
        check_eq("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", PCPlus4D, 32'h0);
        check_eq("wrap_addr", ImemAddrF, 32'h0);

        // Reset mid-WAIT with a late response afterwards.
        redirect_step(2'b01, 32'h40, 1'b0);
        quiet();
        step();
        lat_min = 3; lat_max = 3;
        repeat (2) begin quiet(); step(); end
        do_reset();
        lat_min = 1; lat_max = 1;
        quiet();
        step();
        check_eq("rst_first_addr", ImemAddrF, RESET_PC);
        check_eq("rst_first_req", 32'(ImemReqValidF), 32'd1);
        repeat (2) begin quiet(); step(); end
        check_eq("rst_first_instr", InstrD, mem_data(RESET_PC));
        check_eq("rst_first_pcd", PCD, RESET_PC);

        // Randomized traffic.
        lat_min = 1; lat_max = 3;
        repeat (800) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                rand_inputs();
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline. It sits directly upstream of the hazard unit's StallF/StallD/FlushD/PCSrcE controls and consumes all of them.
- Owns the PC register and the next-PC mux (sequential, branch/JAL, JALR).
- Runs a single-outstanding request/response handshake to instruction memory, with a one-entry hold buffer.
- Delivers InstrD/PCD/PCPlus4D/ValidD to decode, inserting NOP bubbles whenever memory is slow.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- StallF  in  1  hold PCF and do not consume a fetched instruction.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  load bubble into IF/ID.
- PCSrcE  in  2  00 sequential, 01 PCTargetE, 10 JALR target, 11 reserved (treated as 01).
- PCTargetE  in  32  branch/JAL target from execute.
- ALUResultE  in  32  JALR target from execute.
- ImemReqValidF  out  1  request valid.
- ImemAddrF  out  32  request address, {PCF[31:2],2'b00}.
- ImemReqReady  in  1  memory accepts request.
- ImemRspValid  in  1  response valid, single cycle, no backpressure.
- ImemRspData  in  32  response instruction.
- InstrD  out  32  decode instruction.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  InstrD is a real instruction.

Behaviour:
- Reset (async): PCF=RESET_PC, state=REQ, HoldValid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, ImemReqValidF=0 during reset.
- FSM states:
  - REQ: ImemReqValidF=1. On ImemReqReady, go to WAIT. Responses arriving in REQ are ignored (stale after reset).
  - WAIT: request outstanding. On ImemRspValid, the instruction becomes "available" this cycle; go to REQ for the next PC, or stay in WAIT-free HOLD if unconsumed (see hold rule).
  - DROP: outstanding request is stale. The next ImemRspValid is discarded, then go to REQ.
- Only one request outstanding at a time. ImemAddrF must be held stable while ImemReqValidF=1 and ImemReqReady=0.
- Available instruction = ImemRspValid in WAIT, or the HoldValid entry.
- Consume: when the instruction is available and StallF=0, StallD=0, FlushD=0, and PCSrcE=00:
  - IF/ID loads {ImemRspData or hold data, PCF, PCF+4, ValidD=1}.
  - PCF<=PCF+4, HoldValid<=0.
  - The next request issues the following cycle (fetch latency is therefore 1 cycle per request beyond memory latency).
- Hold: a response arriving while StallF or StallD=1 is written into the hold register (HoldValid=1). No new request is issued while HoldValid=1. The held instruction is consumed on the first unstalled cycle.
- No instruction available and no stall: IF/ID loads a bubble (NOP_INSTR, ValidD=0, PCD/PCPlus4D unchanged), PCF holds.
- Redirect (PCSrcE!=00) has priority over StallF and over consume:
  - PCF<=target; JALR target = ALUResultE & ~32'h1.
  - HoldValid<=0.
  - If in WAIT, or in REQ with ImemReqReady=1 this cycle, go to DROP; else go to REQ.
  - A response arriving in the redirect cycle is discarded.
- IF/ID priority: reset > FlushD (bubble: NOP_INSTR, ValidD=0, PCD=0, PCPlus4D=0) > StallD (hold all) > load/bubble.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4=0). No misalignment exception: address bits [1:0] are forced to 0 on ImemAddrF, and PCD keeps the full PCF.
- Simultaneous redirect and response in DROP: the response is dropped, and the state goes to REQ with the new PCF (the newest redirect wins).

Decomposition:
- Shared package pipeline_pkg:
  - fetch_state_t enum {REQ, WAIT, DROP}.
  - pcsrc_t encoding constants (PCSRC_PLUS4=2'b00, PCSRC_TARGET=2'b01, PCSRC_JALR=2'b10).
  - NOP_INSTR constant, XLEN=32.
- One natural sub-module: if_id_reg (IF/ID register with reset/flush/stall priority, bubble load). FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Zero-wait memory (ImemReqReady=1, response 1 cycle after accept), instrs at 0x0/0x4/0x8 -> InstrD sequence with PCD 0x0, 0x4, 0x8, ValidD=1 every 2nd cycle, NOP bubbles (ValidD=0) between.
- StallF=StallD=1 for 3 cycles as the response for PC 0x4 arrives -> HoldValid=1, no new request, InstrD/PCD frozen; after release, PCD=0x4 is loaded and the request for 0x8 issues.
- PCSrcE=01, PCTargetE=0x100 while in WAIT for PC 0x8 -> state DROP, 0x8 response discarded, next ImemAddrF=0x100, FlushD bubble in decode.
- PCSrcE=10, ALUResultE=0x203 -> PCF=0x202, ImemAddrF=0x200, PCD of the fetched instr = 0x202.
- Async reset asserted mid-WAIT, then a late ImemRspValid -> response ignored, outputs at reset values, first request to RESET_PC.
- PCF=0xFFFF_FFFC consumed -> PCPlus4D=0x0, next ImemAddrF=0x0.
